// File: rtl/alu_cmp_pipe_if.sv
// Valid/ready request and result channels for alu_cmp_pipe.
// master: requester side; slave: the compare pipeline.
interface alu_cmp_pipe_if #(
  parameter int W  = 32,
  parameter int TW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;

  modport master (
    output in_valid,
    output in_op,
    output in_a,
    output in_b,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_a,
    input  in_b,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_tag
  );
endinterface

// File: rtl/alu_cmp_pipe.sv
// Two-stage SLTU/SLT/EQ/NE compare pipe with valid/ready on both sides.
// Ports: clk, rst_n, flush, bus (slave), op_count (saturating results).
module alu_cmp_pipe #(
  parameter int W  = 32,
  parameter int TW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  alu_cmp_pipe_if.slave bus,
  output logic [15:0]  op_count
);

  typedef struct packed {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } s2_t;

  localparam logic [1:0] OP_SLTU = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_NE   = 2'b11;

  s1_t  s1_q;
  s2_t  s2_q;
  logic s1_v;
  logic s2_v;

  logic out_fire;
  logic s2_adv;
  logic s1_mv;
  logic s1_adv;
  logic in_fire;

  assign out_fire = s2_v & bus.out_ready;
  assign s2_adv   = ~s2_v | bus.out_ready;
  assign s1_mv    = s1_v & s2_adv;
  assign s1_adv   = ~s1_v | s2_adv;

  // Flush blocks acceptance, so it is folded into in_ready itself.
  assign bus.in_ready = s1_adv & ~flush;
  assign in_fire      = bus.in_valid & bus.in_ready;

  assign bus.out_valid  = s2_v;
  assign bus.out_result = s2_q.res;
  assign bus.out_tag    = s2_q.tag;

  // a - b as a + ~b + 1; carry-out set means a >= b unsigned.
  logic [W:0] diff;
  logic       ltu;
  logic       ovf;
  logic       lt;
  logic       eq;

  assign diff = {1'b0, s1_q.a}
              + {1'b0, ~s1_q.b}
              + {{W{1'b0}}, 1'b1};
  assign ltu  = ~diff[W];
  assign ovf  = (s1_q.a[W-1] ^ s1_q.b[W-1])
              & (diff[W-1] ^ s1_q.a[W-1]);
  assign lt   = diff[W-1] ^ ovf;
  assign eq   = (s1_q.a == s1_q.b);

  logic is_sltu;
  logic is_slt;
  logic is_eq;
  logic is_ne;

  assign is_sltu = (s1_q.op == OP_SLTU);
  assign is_slt  = (s1_q.op == OP_SLT);
  assign is_eq   = (s1_q.op == OP_EQ);
  assign is_ne   = (s1_q.op == OP_NE);

  logic flag;

  always_comb begin
    flag = 1'b0;
    unique case (1'b1)
      is_sltu: flag = ltu;
      is_slt:  flag = lt;
      is_eq:   flag = eq;
      is_ne:   flag = ~eq;
      default: flag = 1'b0;
    endcase
  end

  logic [W-1:0] res;

  assign res = {{(W-1){1'b0}}, flag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= in_fire;
      if (in_fire) begin
        s1_q.op  <= bus.in_op;
        s1_q.a   <= bus.in_a;
        s1_q.b   <= bus.in_b;
        s1_q.tag <= bus.in_tag;
      end
    end
  end

  // S2 data only moves when S1 holds something, keeping
  // out_result/out_tag steady across idle and stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_mv) begin
        s2_q.res <= res;
        s2_q.tag <= s1_q.tag;
      end
    end
  end

  // A handshake completing under flush still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// Directed bench for alu_cmp_pipe with hand-computed expectations.
// Drives/samples 1 time unit after each rising edge.
module tb_alu_cmp_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] op_count;
  int          pass_n;
  int          tot_n;

  alu_cmp_pipe_if #(.W(32), .TW(5)) bus ();

  alu_cmp_pipe #(.W(32), .TW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s obs=%0h exp=%0h", t, obs, exp);
  endtask

  task automatic req(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  task automatic outchk(input string t,
                        input logic [31:0] r,
                        input logic [4:0] tg);
    chk({t, "_v"}, {31'd0, bus.out_valid}, 32'd1);
    chk({t, "_r"}, bus.out_result, r);
    chk({t, "_t"}, {27'd0, bus.out_tag}, {27'd0, tg});
  endtask

  initial begin
    pass_n        = 0;
    tot_n         = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // reset state
    #12;
    chk("rst_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_res", bus.out_result, 32'd0);
    chk("rst_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("rst_cnt", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ir", {31'd0, bus.in_ready}, 32'd1);

    // signed vs unsigned
    req(2'b00, 32'h8000_0000, 32'h1, 5'd3);
    tick();
    chk("sg_ov0", {31'd0, bus.out_valid}, 32'd0);
    req(2'b01, 32'h8000_0000, 32'h1, 5'd4);
    tick();
    outchk("sg_sltu", 32'd0, 5'd3);
    bus.in_valid = 1'b0;
    tick();
    outchk("sg_slt", 32'd1, 5'd4);
    tick();
    chk("sg_idle", {31'd0, bus.out_valid}, 32'd0);
    chk("sg_cnt", {16'd0, op_count}, 32'd2);

    // zero operands and extra signed corners
    req(2'b00, 32'd5, 32'd0, 5'd10);
    tick();
    req(2'b00, 32'd0, 32'd5, 5'd11);
    tick();
    outchk("z_sltu_b0", 32'd0, 5'd10);
    req(2'b10, 32'd0, 32'd0, 5'd12);
    tick();
    outchk("z_sltu_a0", 32'd1, 5'd11);
    req(2'b11, 32'd7, 32'd7, 5'd13);
    tick();
    outchk("z_eq", 32'd1, 5'd12);
    req(2'b01, 32'hFFFF_FFFF, 32'd0, 5'd14);
    tick();
    outchk("z_ne", 32'd0, 5'd13);
    req(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 5'd15);
    tick();
    outchk("slt_m1", 32'd1, 5'd14);
    req(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 5'd16);
    tick();
    outchk("slt_pos", 32'd0, 5'd15);
    bus.in_valid = 1'b0;
    tick();
    outchk("sltu_big", 32'd1, 5'd16);
    tick();
    chk("z_cnt", {16'd0, op_count}, 32'd9);

    // reset mid-stream with a result held
    bus.out_ready = 1'b0;
    req(2'b10, 32'd5, 32'd5, 5'd7);
    tick();
    bus.in_valid = 1'b0;
    tick();
    outchk("mr_pre", 32'd1, 5'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_res", bus.out_result, 32'd0);
    chk("mr_tag", {27'd0, bus.out_tag}, 32'd0);
    chk("mr_cnt", {16'd0, op_count}, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_post_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("mr_post_cnt", {16'd0, op_count}, 32'd0);

    // streaming: 8 back-to-back
    for (int c = 0; c < 10; c++) begin
      if (c < 8) req(2'b00, c, 32'd4, c[4:0]);
      else bus.in_valid = 1'b0;
      if (c < 8) chk("st_ir", {31'd0, bus.in_ready}, 32'd1);
      tick();
      if (c == 0)
        chk("st_lat", {31'd0, bus.out_valid}, 32'd0);
      else if (c <= 8)
        outchk("st_res", (c - 1 < 4) ? 32'd1 : 32'd0,
               5'(c - 1));
    end
    chk("st_end", {31'd0, bus.out_valid}, 32'd0);
    chk("st_cnt", {16'd0, op_count}, 32'd8);

    // backpressure
    bus.out_ready = 1'b0;
    req(2'b10, 32'd1, 32'd1, 5'd20);
    #1;
    chk("bp_ir0", {31'd0, bus.in_ready}, 32'd1);
    tick();
    req(2'b11, 32'd1, 32'd2, 5'd21);
    tick();
    req(2'b01, 32'd2, 32'd1, 5'd22);
    chk("bp_ir_full", {31'd0, bus.in_ready}, 32'd0);
    outchk("bp_hold1", 32'd1, 5'd20);
    tick();
    tick();
    tick();
    chk("bp_ir_still", {31'd0, bus.in_ready}, 32'd0);
    outchk("bp_hold5", 32'd1, 5'd20);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ir_rel", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    outchk("bp_r1", 32'd1, 5'd21);
    tick();
    outchk("bp_r2", 32'd0, 5'd22);
    tick();
    chk("bp_end", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_cnt", {16'd0, op_count}, 32'd11);

    // flush with both stages full
    bus.out_ready = 1'b0;
    req(2'b10, 32'd3, 32'd3, 5'd1);
    tick();
    req(2'b10, 32'd4, 32'd4, 5'd2);
    tick();
    chk("fl_full", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    req(2'b10, 32'd9, 32'd9, 5'd9);
    #1;
    chk("fl_ir", {31'd0, bus.in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_cnt", {16'd0, op_count}, 32'd12);
    tick();
    chk("fl_ov2", {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("fl_ov3", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_cnt2", {16'd0, op_count}, 32'd12);

    // saturation: reach 65535, then 2 more
    req(2'b00, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 65535 - 12; i++) tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("sat_max", {16'd0, op_count}, 32'h0000_FFFF);
    req(2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("sat_hold", {16'd0, op_count}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
